// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the hazard stall controller.
// Holds the HI/LO tracker state encoding and the register-match helper.
package hazard_stall_controller_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MULT_LATENCY_DEF = 4;
  localparam int DIV_LATENCY_DEF  = 32;

  // $0 is hardwired, so a write to it never produces a hazard
  function automatic logic reg_match(
    input logic [4:0] dest,
    input logic [4:0] src,
    input logic       uses
  );
    return uses && (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_stall_controller_muldiv_busy_tracker.sv
// HI/LO unit busy tracker: IDLE/BUSY FSM with a down-counter.
// Done is asserted for the final busy cycle only.
module muldiv_busy_tracker
  import hazard_stall_controller_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int DIV_LATENCY  = DIV_LATENCY_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o
);

  localparam int MAX_LAT =
    (DIV_LATENCY > MULT_LATENCY) ? DIV_LATENCY : MULT_LATENCY;
  localparam int CNT_W = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY - 2);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = is_div_i ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        // a start here is impossible (HI/LO hazard blocks it) and ignored
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          done_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use, ID-branch and HI/LO hazard detection,
// stall/bubble/flush control and a saturating stall-cycle counter.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int DIV_LATENCY  = DIV_LATENCY_DEF,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [4:0]             Rs_ID,
  input  logic [4:0]             Rt_ID,
  input  logic                   UsesRs_ID,
  input  logic                   UsesRt_ID,
  input  logic                   Branch_ID,
  input  logic                   BranchTaken_ID,
  input  logic                   HiLoRead_ID,
  input  logic                   MulDiv_ID,
  input  logic                   MemRead_EX,
  input  logic                   RegWrite_EX,
  input  logic [4:0]             WriteRegAddress_EX,
  input  logic                   MulDivStart_EX,
  input  logic                   MulDivIsDiv_EX,
  input  logic                   MemRead_MEM,
  input  logic                   RegWrite_MEM,
  input  logic [4:0]             WriteRegAddress_MEM,
  output logic                   PCWrite,
  output logic                   IFIDWrite,
  output logic                   IDEXBubble,
  output logic                   IFIDFlush,
  output logic                   MulDivBusy,
  output logic                   MulDivDone,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic ex_hit, mem_hit;
  logic load_use, branch_haz, hilo_haz;
  logic stall;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // a load in MEM is already covered by its RegWrite
  logic unused_mem_read;
  assign unused_mem_read = MemRead_MEM;

  muldiv_busy_tracker #(
    .MULT_LATENCY(MULT_LATENCY),
    .DIV_LATENCY (DIV_LATENCY)
  ) u_tracker (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .start_i (MulDivStart_EX),
    .is_div_i(MulDivIsDiv_EX),
    .busy_o  (MulDivBusy),
    .done_o  (MulDivDone)
  );

  assign ex_hit =
    reg_match(WriteRegAddress_EX, Rs_ID, UsesRs_ID) ||
    reg_match(WriteRegAddress_EX, Rt_ID, UsesRt_ID);

  assign mem_hit =
    reg_match(WriteRegAddress_MEM, Rs_ID, UsesRs_ID) ||
    reg_match(WriteRegAddress_MEM, Rt_ID, UsesRt_ID);

  assign load_use = MemRead_EX && ex_hit;

  // ID compare only sees WB forwarding, so EX and MEM writers stall
  assign branch_haz = Branch_ID &&
    ((RegWrite_EX && ex_hit) || (RegWrite_MEM && mem_hit));

  assign hilo_haz = (HiLoRead_ID || MulDiv_ID) &&
    (MulDivBusy || MulDivStart_EX);

  assign stall = Rst_n && (load_use || branch_haz || hilo_haz);

  assign PCWrite    = !stall;
  assign IFIDWrite  = !stall;
  assign IDEXBubble = stall;
  assign IFIDFlush  = Rst_n && BranchTaken_ID && !stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: cycle model plus directed vectors.
module tb_hazard_stall_controller;

  localparam int ML = 4;
  localparam int DL = 32;
  localparam int SW = 4;
  localparam int SAT = (1 << SW) - 1;

  logic Clk = 1'b0;
  logic Rst_n;
  logic [4:0] Rs_ID, Rt_ID;
  logic UsesRs_ID, UsesRt_ID;
  logic Branch_ID, BranchTaken_ID, HiLoRead_ID, MulDiv_ID;
  logic MemRead_EX, RegWrite_EX;
  logic [4:0] WriteRegAddress_EX;
  logic MulDivStart_EX, MulDivIsDiv_EX;
  logic MemRead_MEM, RegWrite_MEM;
  logic [4:0] WriteRegAddress_MEM;
  logic PCWrite, IFIDWrite, IDEXBubble, IFIDFlush;
  logic MulDivBusy, MulDivDone;
  logic [SW-1:0] StallCount;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  hazard_stall_controller #(
    .MULT_LATENCY(ML),
    .DIV_LATENCY (DL),
    .STALL_CNT_W (SW)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
    .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
    .HiLoRead_ID(HiLoRead_ID), .MulDiv_ID(MulDiv_ID),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
    .WriteRegAddress_EX(WriteRegAddress_EX),
    .MulDivStart_EX(MulDivStart_EX), .MulDivIsDiv_EX(MulDivIsDiv_EX),
    .MemRead_MEM(MemRead_MEM), .RegWrite_MEM(RegWrite_MEM),
    .WriteRegAddress_MEM(WriteRegAddress_MEM),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IDEXBubble(IDEXBubble), .IFIDFlush(IFIDFlush),
    .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone),
    .StallCount(StallCount)
  );

  // model: cycles the HI/LO unit stays busy, and stall cycles seen
  int rem = 0;
  int scnt = 0;

  function automatic bit uses_reg(logic [4:0] d, logic [4:0] s, logic u);
    return u && d != 0 && d == s;
  endfunction

  function automatic bit m_stall();
    bit ld, br, hl, ex, mem;
    ex = uses_reg(WriteRegAddress_EX, Rs_ID, UsesRs_ID) ||
         uses_reg(WriteRegAddress_EX, Rt_ID, UsesRt_ID);
    mem = uses_reg(WriteRegAddress_MEM, Rs_ID, UsesRs_ID) ||
          uses_reg(WriteRegAddress_MEM, Rt_ID, UsesRt_ID);
    ld = MemRead_EX && ex;
    br = Branch_ID && ((RegWrite_EX && ex) || (RegWrite_MEM && mem));
    hl = (HiLoRead_ID || MulDiv_ID) && (rem > 0 || MulDivStart_EX);
    return Rst_n && (ld || br || hl);
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rem = 0;
      scnt = 0;
    end else begin
      if (m_stall() && scnt < SAT) scnt = scnt + 1;
      if (rem > 0) rem = rem - 1;
      else if (MulDivStart_EX) rem = (MulDivIsDiv_EX ? DL : ML) - 1;
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    bit st;
    st = m_stall();
    chk("PCWrite", PCWrite, !st);
    chk("IFIDWrite", IFIDWrite, !st);
    chk("IDEXBubble", IDEXBubble, st);
    chk("IFIDFlush", IFIDFlush, Rst_n && BranchTaken_ID && !st);
    chk("MulDivBusy", MulDivBusy, rem > 0);
    chk("MulDivDone", MulDivDone, rem == 1);
    chk("StallCount", StallCount, scnt);
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic look();
    @(negedge Clk);
    #2;
  endtask

  task automatic clear_in();
    Rs_ID = 0; Rt_ID = 0; UsesRs_ID = 0; UsesRt_ID = 0;
    Branch_ID = 0; BranchTaken_ID = 0; HiLoRead_ID = 0; MulDiv_ID = 0;
    MemRead_EX = 0; RegWrite_EX = 0; WriteRegAddress_EX = 0;
    MulDivStart_EX = 0; MulDivIsDiv_EX = 0;
    MemRead_MEM = 0; RegWrite_MEM = 0; WriteRegAddress_MEM = 0;
  endtask

  initial begin
    int nst, nbusy, ndone, done_at;
    clear_in();
    Rst_n = 1'b0;
    look();
    chk("rst_PCWrite", PCWrite, 1);
    chk("rst_Busy", MulDivBusy, 0);
    chk("rst_Count", StallCount, 0);
    look();
    Rst_n = 1'b1;

    // load-use
    cyc();
    MemRead_EX = 1; WriteRegAddress_EX = 8; Rs_ID = 8; UsesRs_ID = 1;
    look();
    chk("lu_PCWrite", PCWrite, 0);
    chk("lu_Bubble", IDEXBubble, 1);
    cyc();
    clear_in();
    Rs_ID = 8; UsesRs_ID = 1;
    look();
    chk("lu_release", PCWrite, 1);
    chk("lu_count", StallCount, 1);

    // $0 destination
    cyc();
    MemRead_EX = 1; WriteRegAddress_EX = 0; Rs_ID = 0; UsesRs_ID = 1;
    look();
    chk("zero_PCWrite", PCWrite, 1);
    cyc();
    clear_in();
    look();
    chk("zero_count", StallCount, 1);

    // branch dependence: EX, then MEM, then WB
    cyc();
    Branch_ID = 1; BranchTaken_ID = 1; Rt_ID = 5; UsesRt_ID = 1;
    RegWrite_EX = 1; WriteRegAddress_EX = 5;
    look();
    chk("br_ex_stall", PCWrite, 0);
    chk("br_ex_flush", IFIDFlush, 0);
    cyc();
    RegWrite_EX = 0; WriteRegAddress_EX = 0;
    RegWrite_MEM = 1; WriteRegAddress_MEM = 5;
    look();
    chk("br_mem_stall", PCWrite, 0);
    cyc();
    RegWrite_MEM = 0; WriteRegAddress_MEM = 0;
    look();
    chk("br_wb_go", PCWrite, 1);
    chk("br_wb_flush", IFIDFlush, 1);
    cyc();
    clear_in();
    look();
    chk("br_count", StallCount, 3);

    // multiply with dependent mfhi held in ID
    cyc();
    MulDivStart_EX = 1; MulDivIsDiv_EX = 0; HiLoRead_ID = 1;
    nst = 0; nbusy = 0; ndone = 0; done_at = -1;
    for (int i = 0; i < 7; i++) begin
      look();
      if (!PCWrite) nst++;
      if (MulDivBusy) nbusy++;
      if (MulDivDone) begin ndone++; done_at = i; end
      if (i == 4) chk("mul_release", PCWrite, 1);
      cyc();
      MulDivStart_EX = 0;
    end
    chk("mul_stalls", nst, 4);
    chk("mul_busy", nbusy, 3);
    chk("mul_done", ndone, 1);
    chk("mul_done_at", done_at, 3);
    clear_in();
    look();
    chk("mul_count", StallCount, 7);

    // divide
    cyc();
    MulDivStart_EX = 1; MulDivIsDiv_EX = 1; HiLoRead_ID = 1;
    nst = 0; nbusy = 0; ndone = 0;
    for (int i = 0; i < 36; i++) begin
      look();
      if (!PCWrite) nst++;
      if (MulDivBusy) nbusy++;
      if (MulDivDone) ndone++;
      cyc();
      MulDivStart_EX = 0;
    end
    chk("div_stalls", nst, 32);
    chk("div_busy", nbusy, 31);
    chk("div_done", ndone, 1);
    clear_in();
    look();
    chk("div_count_sat", StallCount, 15);

    // reset while busy
    cyc();
    MulDivStart_EX = 1; MulDivIsDiv_EX = 1;
    for (int i = 0; i < 21; i++) begin
      cyc();
      MulDivStart_EX = 0;
    end
    look();
    chk("mid_busy", MulDivBusy, 1);
    Rst_n = 1'b0;
    #1;
    chk("abort_busy", MulDivBusy, 0);
    chk("abort_done", MulDivDone, 0);
    chk("abort_count", StallCount, 0);
    chk("abort_pc", PCWrite, 1);
    look();
    Rst_n = 1'b1;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      look();
      if (MulDivDone) ndone++;
      if (MulDivBusy) nbusy++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", nbusy, 0);

    // saturation under continuous stall
    cyc();
    MemRead_EX = 1; WriteRegAddress_EX = 8; Rs_ID = 8; UsesRs_ID = 1;
    repeat (20) cyc();
    look();
    chk("sat_stall", PCWrite, 0);
    chk("sat_count", StallCount, 15);
    cyc();
    clear_in();
    look();
    chk("sat_hold", StallCount, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
